obstacle_field: RTL and testbench

- Parametrised successor to the two-slot obstacle generator, supporting NUM_OBS independent obstacle slots.
- Each slot has a valid flag, a staggered spawn scheduler, a per-slot flicker bit and a difficulty ramp that shortens the movement tick period over time.
- Sits between the game-state FSM and the renderer/collision logic.
- Emits per-slot position, lane and type, plus a pass-count pulse for the score block.

---
 rtl/obstacle_pkg.sv | 22 ++
 rtl/obs_lfsr.sv | 34 +++
 rtl/obstacle_field.sv | 205 ++++++++++++++++++++
 tb/tb_obstacle_field.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared types and constants for the obstacle field
package obstacle_pkg;

   typedef enum logic [1:0] {
      GS_IDLE  = 2'b00,
      GS_RUN   = 2'b01,
      GS_PAUSE = 2'b10,
      GS_OVER  = 2'b11
   } game_state_e;

   typedef enum logic [1:0] {
      OT_ROCK   = 2'b00,
      OT_CACTUS = 2'b01,
      OT_BIRD   = 2'b10,
      OT_PIT    = 2'b11
   } obs_type_e;

   // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/obs_lfsr.sv
// rtl/obs_lfsr.sv - 8-bit Galois LFSR with enable, reseeded on reset
module obs_lfsr
   import obstacle_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en_i,
   output logic [3:0] rnd_o
);

   logic [7:0] state_q;
   logic [7:0] state_d;

   // one Galois step: shift right, fold the taps in when a one falls out
   always_comb begin
      state_d = state_q;
      if (en_i) begin
         state_d = {1'b0, state_q[7:1]} ^ (state_q[0] ? LFSR_TAPS : 8'h00);
      end
   end

   // state register, returns to the seed on reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= LFSR_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   // only lane and type bits leave the block
   assign rnd_o = state_q[3:0];

endmodule

// File: rtl/obstacle_field.sv
// rtl/obstacle_field.sv - NUM_OBS-slot obstacle scheduler with speed ramp
module obstacle_field
   import obstacle_pkg::*;
#(
   parameter int NUM_OBS    = 4,
   parameter int XW         = 10,
   parameter int X_START    = 740,
   parameter int DIV_W      = 10,
   parameter int SPAWN_GAP  = 180,
   parameter int RAMP_TICKS = 1024,
   parameter int MAX_SPEED  = 3
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [1:0]                       game_state,
   output logic [NUM_OBS*XW-1:0]            obs_x,
   output logic [NUM_OBS*2-1:0]             obs_lane,
   output logic [NUM_OBS*2-1:0]             obs_type,
   output logic [NUM_OBS-1:0]               obs_active,
   output logic [NUM_OBS-1:0]               obs_flick,
   output logic                             tick,
   output logic [$clog2(NUM_OBS+1)-1:0]     passed,
   output logic [$clog2(MAX_SPEED+1)-1:0]   speed_lvl
);

   localparam int PW = $clog2(NUM_OBS+1);
   localparam int SW = $clog2(MAX_SPEED+1);
   localparam int GW = $clog2(SPAWN_GAP+1);
   localparam int RW = $clog2(RAMP_TICKS+1);
   localparam int IW = $clog2(NUM_OBS);
   localparam logic [DIV_W-1:0] DIV_BASE = '1;

   game_state_e gs;
   logic        run;
   logic        clear;
   logic        lfsr_rst_n;
   logic [3:0]  rnd;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [RW-1:0]    ramp_cnt_q, ramp_cnt_d;
   logic [SW-1:0]    speed_q, speed_d;
   logic             tick_q, tick_d;
   logic [PW-1:0]    passed_q, passed_d;

   logic [DIV_W-1:0] period;
   logic             tick_now;
   logic             do_spawn;
   logic             spawn_any;
   logic [IW-1:0]    spawn_idx;
   logic [NUM_OBS-1:0] expire;

   // idle and game over behave exactly like reset; pause simply freezes
   assign gs         = game_state_e'(game_state);
   assign run        = reset_n && (gs == GS_RUN);
   assign clear      = !reset_n || (gs == GS_IDLE) || (gs == GS_OVER);
   assign lfsr_rst_n = !clear;

   obs_lfsr u_lfsr (
      .clk     (clk),
      .reset_n (lfsr_rst_n),
      .en_i    (run),
      .rnd_o   (rnd)
   );

   // movement period shrinks with speed level, never below one
   always_comb begin
      period = DIV_BASE >> speed_q;
      if (period == '0) begin
         period = DIV_W'(1);
      end
   end

   assign tick_now = run && (div_cnt_q >= period);

   // lowest-index slot that was free before this tick
   always_comb begin
      spawn_any = 1'b0;
      spawn_idx = '0;
      for (int i = NUM_OBS-1; i >= 0; i--) begin
         if (!obs_active[i]) begin
            spawn_any = 1'b1;
            spawn_idx = IW'(i);
         end
      end
   end

   assign do_spawn = tick_now && spawn_any && (gap_cnt_q >= GW'(SPAWN_GAP));

   // divider, spawn gap, ramp and registered pulses
   always_comb begin
      div_cnt_d  = div_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      ramp_cnt_d = ramp_cnt_q;
      speed_d    = speed_q;
      tick_d     = 1'b0;
      passed_d   = '0;
      if (run) begin
         div_cnt_d = tick_now ? '0 : div_cnt_q + DIV_W'(1);
         tick_d    = tick_now;
         if (tick_now) begin
            for (int i = 0; i < NUM_OBS; i++) begin
               passed_d = passed_d + PW'(expire[i]);
            end
            if (do_spawn) begin
               gap_cnt_d = '0;
            end else if (gap_cnt_q < GW'(SPAWN_GAP)) begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
            if (ramp_cnt_q == RW'(RAMP_TICKS-1)) begin
               ramp_cnt_d = '0;
               if (speed_q < SW'(MAX_SPEED)) begin
                  speed_d = speed_q + SW'(1);
               end
            end else begin
               ramp_cnt_d = ramp_cnt_q + RW'(1);
            end
         end
      end
   end

   // shared state registers
   always_ff @(posedge clk) begin
      if (clear) begin
         div_cnt_q  <= '0;
         gap_cnt_q  <= GW'(SPAWN_GAP);
         ramp_cnt_q <= '0;
         speed_q    <= '0;
         tick_q     <= 1'b0;
         passed_q   <= '0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         ramp_cnt_q <= ramp_cnt_d;
         speed_q    <= speed_d;
         tick_q     <= tick_d;
         passed_q   <= passed_d;
      end
   end

   assign tick      = tick_q;
   assign passed    = passed_q;
   assign speed_lvl = speed_q;

   for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
      logic [XW-1:0] x_q, x_d;
      logic [1:0]    lane_q, lane_d;
      obs_type_e     type_q, type_d;
      logic          active_q, active_d;
      logic          flick_q, flick_d;
      logic          spawn_here;

      assign expire[g]  = tick_now && active_q && (x_q == '0);
      assign spawn_here = do_spawn && (spawn_idx == IW'(g));

      // per-slot move, expiry and spawn on a tick
      always_comb begin
         x_d      = x_q;
         lane_d   = lane_q;
         type_d   = type_q;
         active_d = active_q;
         flick_d  = flick_q;
         if (tick_now) begin
            if (active_q) begin
               if (x_q == '0) begin
                  active_d = 1'b0;
               end else begin
                  x_d     = x_q - XW'(1);
                  flick_d = !flick_q;
               end
            end else if (spawn_here) begin
               active_d = 1'b1;
               x_d      = XW'(X_START);
               lane_d   = rnd[1:0];
               type_d   = obs_type_e'(rnd[3:2]);
               flick_d  = 1'b0;
            end
         end
      end

      // per-slot registers; odd slots start with flicker set
      always_ff @(posedge clk) begin
         if (clear) begin
            x_q      <= XW'(X_START);
            lane_q   <= '0;
            type_q   <= OT_ROCK;
            active_q <= 1'b0;
            flick_q  <= (g % 2 == 1);
         end else begin
            x_q      <= x_d;
            lane_q   <= lane_d;
            type_q   <= type_d;
            active_q <= active_d;
            flick_q  <= flick_d;
         end
      end

      assign obs_x[g*XW +: XW]  = x_q;
      assign obs_lane[g*2 +: 2] = lane_q;
      assign obs_type[g*2 +: 2] = type_q;
      assign obs_active[g]      = active_q;
      assign obs_flick[g]       = flick_q;
   end

endmodule

// File: tb/tb_obstacle_field.sv
// tb/tb_obstacle_field.sv - directed self-checking bench for obstacle_field
module tb_obstacle_field;

   localparam int NUM_OBS    = 2;
   localparam int XW         = 4;
   localparam int X_START    = 5;
   localparam int DIV_W      = 2;
   localparam int SPAWN_GAP  = 2;
   localparam int RAMP_TICKS = 4;
   localparam int MAX_SPEED  = 1;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] game_state;
   logic [7:0] obs_x;
   logic [3:0] obs_lane;
   logic [3:0] obs_type;
   logic [1:0] obs_active;
   logic [1:0] obs_flick;
   logic       tick;
   logic [1:0] passed;
   logic       speed_lvl;

   int checks     = 0;
   int errors     = 0;
   int run_cycles = 0;

   logic [7:0]  l;
   logic [31:0] snap;
   int          changes;
   int          tick_seen;

   obstacle_field #(
      .NUM_OBS    (NUM_OBS),
      .XW         (XW),
      .X_START    (X_START),
      .DIV_W      (DIV_W),
      .SPAWN_GAP  (SPAWN_GAP),
      .RAMP_TICKS (RAMP_TICKS),
      .MAX_SPEED  (MAX_SPEED)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .game_state (game_state),
      .obs_x      (obs_x),
      .obs_lane   (obs_lane),
      .obs_type   (obs_type),
      .obs_active (obs_active),
      .obs_flick  (obs_flick),
      .tick       (tick),
      .passed     (passed),
      .speed_lvl  (speed_lvl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_after(input int n);
      logic [7:0] s;
      s = 8'hA5;
      for (int k = 0; k < n; k++) begin
         s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
      end
      return s;
   endfunction

   task automatic step();
      logic run_edge;
      logic clr_edge;
      run_edge = reset_n && (game_state == 2'b01);
      clr_edge = !reset_n || (game_state == 2'b00) || (game_state == 2'b11);
      @(posedge clk);
      #1;
      if (run_edge) run_cycles++;
      else if (clr_edge) run_cycles = 0;
   endtask

   task automatic wait_tick(input string tag, input int exp_cycles);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < 20);
      chk(tag, n, exp_cycles);
   endtask

   function automatic logic [31:0] outs();
      return {obs_x, obs_lane, obs_type, obs_active, obs_flick, speed_lvl, passed, tick};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      game_state = 2'b01;
      step();
      step();
      chk("rst_active", obs_active, 2'b00);
      chk("rst_x", obs_x, 8'h55);
      chk("rst_flick", obs_flick, 2'b10);
      chk("rst_speed", speed_lvl, 0);
      chk("rst_tick", tick, 0);
      chk("rst_passed", passed, 0);

      reset_n = 1'b1;
      wait_tick("t1_gap", 4);
      chk("t1_active", obs_active, 2'b01);
      chk("t1_x0", obs_x[3:0], 5);
      chk("t1_lane0", obs_lane[1:0], 2);
      chk("t1_type0", obs_type[1:0], 0);
      chk("t1_flick0", obs_flick[0], 0);

      wait_tick("t2_gap", 4);
      chk("t2_x0", obs_x[3:0], 4);
      chk("t2_flick0", obs_flick[0], 1);
      chk("t2_active", obs_active, 2'b01);

      wait_tick("t3_gap", 4);
      chk("t3_x0", obs_x[3:0], 3);

      wait_tick("t4_gap", 4);
      l = lfsr_after(run_cycles - 1);
      chk("t4_active", obs_active, 2'b11);
      chk("t4_x1", obs_x[7:4], 5);
      chk("t4_lane1", obs_lane[3:2], l[1:0]);
      chk("t4_type1", obs_type[3:2], l[3:2]);
      chk("t4_flick1", obs_flick[1], 0);
      chk("t4_speed", speed_lvl, 1);
      chk("t4_x0", obs_x[3:0], 2);

      wait_tick("t5_gap", 2);
      chk("t5_x0", obs_x[3:0], 1);
      chk("t5_x1", obs_x[7:4], 4);

      step();
      snap       = outs();
      game_state = 2'b10;
      changes    = 0;
      tick_seen  = 0;
      repeat (20) begin
         step();
         if (outs() !== snap) changes++;
         if (tick) tick_seen++;
      end
      chk("pause_hold", changes, 0);
      chk("pause_tick", tick_seen, 0);

      game_state = 2'b01;
      wait_tick("resume_gap", 1);
      chk("t6_x0", obs_x[3:0], 0);
      chk("t6_x1", obs_x[7:4], 3);

      wait_tick("t7_gap", 2);
      chk("t7_active", obs_active, 2'b10);
      chk("t7_passed", passed, 1);
      chk("t7_x0_hold", obs_x[3:0], 0);
      step();
      chk("t7_passed_pulse", passed, 0);
      chk("t7_tick_pulse", tick, 0);

      wait_tick("t8_gap", 1);
      l = lfsr_after(run_cycles - 1);
      chk("t8_active", obs_active, 2'b11);
      chk("t8_x0", obs_x[3:0], 5);
      chk("t8_lane0", obs_lane[1:0], l[1:0]);
      chk("t8_type0", obs_type[1:0], l[3:2]);
      chk("t8_x1", obs_x[7:4], 1);
      chk("t8_speed", speed_lvl, 1);

      wait_tick("t9_gap", 2);
      chk("t9_x1", obs_x[7:4], 0);
      wait_tick("t10_gap", 2);
      chk("t10_passed", passed, 1);
      chk("t10_active", obs_active, 2'b01);
      wait_tick("t11_gap", 2);
      chk("t11_active", obs_active, 2'b11);
      chk("t11_x1", obs_x[7:4], 5);
      wait_tick("t12_gap", 2);
      chk("t12_speed", speed_lvl, 1);
      chk("t12_x0", obs_x[3:0], 1);

      game_state = 2'b11;
      step();
      chk("over_active", obs_active, 2'b00);
      chk("over_x", obs_x, 8'h55);
      chk("over_flick", obs_flick, 2'b10);
      chk("over_lane", obs_lane, 0);
      chk("over_type", obs_type, 0);
      chk("over_speed", speed_lvl, 0);
      chk("over_tick", tick, 0);
      chk("over_passed", passed, 0);

      game_state = 2'b01;
      wait_tick("restart_gap", 4);
      chk("restart_lane0", obs_lane[1:0], 2);
      chk("restart_active", obs_active, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
